// File: rtl/uart_rx.sv
// 8N1 serial receiver: input synchronizer, start/data/stop sampling FSM with
// break handling, and a small receive FIFO presented on a valid/ready stream.
module uart_rx #(
    parameter int CLKS_PER_BIT = 1,
    parameter int SYNC_STAGES  = 2,
    parameter int DEPTH        = 4
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int HALF  = (CLKS_PER_BIT - 1) / 2;
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'((HALF > 0) ? (HALF - 1) : 0);
    localparam logic [AW-1:0]    PTR_ONE   = AW'(1);
    localparam logic [AW:0]      OCC_ZERO  = {(AW + 1){1'b0}};
    localparam logic [AW:0]      OCC_ONE   = (AW + 1)'(1);
    localparam logic [AW:0]      OCC_FULL  = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_e;

    logic rx_s;

    generate
        if (SYNC_STAGES > 0) begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;

            // Metastability synchronizer, preset to the idle level.
            always_ff @(posedge CLK or negedge RESETN) begin
                if (!RESETN) begin
                    sync_q <= {SYNC_STAGES{1'b1}};
                end else begin
                    sync_q[0] <= rx;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end

            assign rx_s = sync_q[SYNC_STAGES-1];
        end else begin : g_nosync
            assign rx_s = rx;
        end
    endgenerate

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;
    logic             frame_err_q;

    logic sample_s;
    logic push_s;
    logic ferr_s;

    // cnt_q counts down to the next sample point; zero marks a sample cycle.
    assign sample_s = (cnt_q == CNT_ZERO);
    assign push_s   = (state_q == S_STOP) && sample_s && rx_s;
    assign ferr_s   = (state_q == S_STOP) && sample_s && !rx_s;

    // Frame sequencer: start qualification, MSB-first shift, stop check, break wait.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q     <= S_IDLE;
            cnt_q       <= CNT_ZERO;
            bit_q       <= 3'd0;
            shift_q     <= 8'h00;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= ferr_s;
            case (state_q)
                S_IDLE: begin
                    if (!rx_s) begin
                        bit_q <= 3'd0;
                        // With no half-bit offset the start bit is confirmed right here.
                        if (HALF == 0) begin
                            state_q <= S_DATA;
                            cnt_q   <= BIT_LAST;
                        end else begin
                            state_q <= S_START;
                            cnt_q   <= HALF_LAST;
                        end
                    end
                end
                S_START: begin
                    if (sample_s) begin
                        if (rx_s) begin
                            state_q <= S_IDLE;
                        end else begin
                            state_q <= S_DATA;
                            cnt_q   <= BIT_LAST;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                S_DATA: begin
                    if (sample_s) begin
                        shift_q <= {shift_q[6:0], rx_s};
                        cnt_q   <= BIT_LAST;
                        if (bit_q == 3'd7) begin
                            state_q <= S_STOP;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                S_STOP: begin
                    if (sample_s) begin
                        state_q <= rx_s ? S_IDLE : S_BREAK;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                S_BREAK: begin
                    if (rx_s) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          overrun_q, overrun_d;

    logic full_s;
    logic pop_s;
    logic wr_en_s;

    assign full_s  = (count_q == OCC_FULL);
    assign pop_s   = valid_q && ready;
    assign wr_en_s = push_s && (!full_s || pop_s);

    // FIFO next state; data_d pre-computes the head so data/valid are registered.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;

        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({wr_en_s, pop_s})
            2'b10:   count_d = count_q + OCC_ONE;
            2'b01:   count_d = count_q - OCC_ONE;
            default: count_d = count_q;
        endcase

        valid_d   = (count_d != OCC_ZERO);
        overrun_d = push_s && !wr_en_s;

        // The new head is the byte being written when it lands at the read slot.
        if (count_d == OCC_ZERO) begin
            data_d = data_q;
        end else if (wr_en_s && (wr_ptr_q == rd_ptr_d)) begin
            data_d = shift_q;
        end else begin
            data_d = mem_q[rd_ptr_d];
        end
    end

    // Receive FIFO storage.
    always_ff @(posedge CLK) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    // FIFO pointers, occupancy and registered stream/status outputs.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            wr_ptr_q  <= {AW{1'b0}};
            rd_ptr_q  <= {AW{1'b0}};
            count_q   <= OCC_ZERO;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver for the 8N1 frame produced by the UART transmit stage: start bit 0, 8 data bits MSB first, stop bit 1, idle line 1.
- Sits directly downstream of the transmitter (or on the external line) and recovers bytes.
- Buffers received bytes in a small FIFO and presents them on a valid/ready stream.
- Flags framing errors and FIFO overruns.

Parameters:
- CLKS_PER_BIT, 1, clock cycles per serial bit (>=1). A value of 1 matches the transmitter's one-bit-per-clock timing.
- SYNC_STAGES, 2, flip-flops in the rx input synchronizer (0 = rx used directly).
- DEPTH, 4, receive FIFO entries (power of two, >=2).

Ports:
- CLK  input  1  clock, all logic on rising edge.
- RESETN  input  1  asynchronous active-low reset.
- rx  input  1  serial line, idle high.
- data  output  8  byte at FIFO head.
- valid  output  1  data holds a received byte.
- ready  input  1  consumer accepts data when valid && ready.
- frame_err  output  1  one-cycle pulse: stop bit sampled 0.
- overrun  output  1  one-cycle pulse: good byte dropped because FIFO full.

Behaviour:
- Reset: CLK single clock; RESETN asynchronous, active-low. While RESETN=0:
  - state=IDLE, FIFO empty, valid=0, data=0, frame_err=0, overrun=0.
  - Synchronizer flops preset to 1.
  - Reset mid-frame abandons the frame; no partial byte is ever pushed.
- rx_s is rx delayed by SYNC_STAGES cycles. All timing below refers to rx_s.
- HALF = (CLKS_PER_BIT-1)/2 (integer division).
- Let t be the first cycle in IDLE with rx_s=0. Sample k (k=0 start, 1..8 data MSB first, 9 stop) is taken at cycle t + HALF + k*CLKS_PER_BIT.
- State machine:
  - IDLE: on rx_s=0 go to START, load bit counter with HALF.
  - START: at sample 0, if rx_s=1 this is a glitch: return to IDLE, nothing flagged. Otherwise go to DATA. When HALF=0, sample 0 is cycle t itself and the start bit is confirmed there.
  - DATA: samples 1..8 shift into the byte; sample 1 is bit 7.
  - STOP: at sample 9:
    - rx_s=1: push byte to FIFO, go to IDLE.
    - rx_s=0: pulse frame_err for the cycle after the sample, discard the byte, go to BREAK.
  - BREAK: wait for rx_s=1, then go to IDLE. A held-low line yields exactly one frame_err.
- Back-to-back: IDLE is re-entered the cycle after sample 9, so a start bit in the very next bit period is detected. With CLKS_PER_BIT=1, frames spaced 10 cycles apart are all received.
- FIFO:
  - Push occurs on the clock edge of the good stop sample. valid and data reflect the new entry from the next cycle; latency from stop sample to valid is 1 cycle when empty.
  - Pop on valid && ready. data/valid update the next cycle. Order is preserved.
  - Full and push without pop: byte dropped, FIFO unchanged, overrun pulses 1 cycle.
  - Full with push and pop in the same cycle: both happen, no overrun.
  - Empty: valid=0, and data holds its last value (don't-care).
  - Pointers wrap modulo DEPTH; occupancy counter is log2(DEPTH)+1 bits.
- The receive path never stalls on ready; backpressure only causes overrun.
- frame_err and overrun never assert in the same cycle for the same frame.

Test Plan:
- CLKS_PER_BIT=1, SYNC_STAGES=0, ready=1: drive frame for 0xA5 (rx = 0,1,0,1,0,0,1,0,1,1) -> valid=1 for one cycle with data=0xA5, one cycle after the stop sample; frame_err=0.
- CLKS_PER_BIT=1: drive the transmitter-produced serial line for three back-to-back bytes 0x00, 0xFF, 0x3C with no idle gap -> three pops in order 0x00, 0xFF, 0x3C, no errors.
- CLKS_PER_BIT=4: 1-cycle low glitch on idle line -> returns to IDLE, no frame_err, valid stays 0; then a full 0x81 frame -> data=0x81.
- Frame 0x55 with stop bit 0, then line held low 30 cycles, then high -> exactly one frame_err pulse, nothing pushed; following 0x12 frame received correctly.
- ready=0, DEPTH=4: send 5 bytes 0x01..0x05 -> overrun pulses once, on the 5th stop; raising ready yields 0x01..0x04. Repeat with ready raised during the 5th stop cycle while full -> no overrun, 0x05 retained.
- Assert RESETN=0 mid-data of a frame with 2 bytes queued -> valid=0 immediately (asynchronously); after release, the next full frame 0xC3 is received alone.
